// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/bubble control.
// Detects the hazards that forwarding cannot cover:
//   - load-use in EX
//   - a branch/jr in ID that depends on a load
//   - an ID instruction that needs the mult/div unit while it is still busy
// It also owns the mult/div busy FSM, the HI/LO write strobe and a
// saturating stall-cycle counter.
module hazard_unit #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  rsID,
    input  logic [4:0]  rtID,
    input  logic        usesRsID,
    input  logic        usesRtID,
    input  logic        branchID,
    input  logic        hiloReadID,
    input  logic        mulDivID,
    input  logic [4:0]  destRegEX,
    input  logic        regWriteEX,
    input  logic        memReadEX,
    input  logic [4:0]  destRegMEM,
    input  logic        memReadMEM,
    input  logic        startMulDiv,
    input  logic        isDivEX,
    output logic        stallPC,
    output logic        stallIFID,
    output logic        bubbleIDEX,
    output logic        mulDivBusy,
    output logic        hiloWrite,
    output logic        protoError,
    output logic [15:0] stallCount
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Counter preload values: the BUSY state lasts exactly LAT cycles, so the
    // counter starts at LAT-1 and DONE is entered when it reaches zero.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    logic [1:0]       state;
    logic [1:0]       stateNext;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;

    logic matchRsEX;
    logic matchRtEX;
    logic matchRsMEM;
    logic matchRtMEM;
    logic loadInEX;
    logic loadUse;
    logic branchLoad;
    logic mdHazard;
    logic stall;

    // Register-operand matches; destination $0 never creates a dependency.
    always_comb begin
        matchRsEX  = usesRsID && (destRegEX  != 5'd0) && (rsID == destRegEX);
        matchRtEX  = usesRtID && (destRegEX  != 5'd0) && (rtID == destRegEX);
        matchRsMEM = usesRsID && (destRegMEM != 5'd0) && (rsID == destRegMEM);
        matchRtMEM = usesRtID && (destRegMEM != 5'd0) && (rtID == destRegMEM);
    end

    // Hazard causes are simply OR-ed; every cause needs the same action.
    // ALU results in EX are forwarded to ID, so only loads stall a branch.
    always_comb begin
        loadInEX   = memReadEX && regWriteEX;
        loadUse    = loadInEX && (matchRsEX || matchRtEX);
        branchLoad = branchID && ((loadInEX && (matchRsEX || matchRtEX)) ||
                                  (memReadMEM && (matchRsMEM || matchRtMEM)));
        mdHazard   = mulDivBusy && (hiloReadID || mulDivID);
        stall      = loadUse || branchLoad || mdHazard;
        stallPC    = stall;
        stallIFID  = stall;
        bubbleIDEX = stall;
    end

    // Busy covers DONE too: HI/LO is only written at the end of DONE and
    // there is no HI/LO forwarding path.
    always_comb begin
        mulDivBusy = (state != IDLE);
        hiloWrite  = (state == DONE);
    end

    // Next-state logic for the mult/div occupancy FSM.
    always_comb begin
        stateNext = state;
        countNext = count;
        case (state)
            IDLE: begin
                if (startMulDiv) begin
                    stateNext = BUSY;
                    countNext = isDivEX ? DIV_LOAD : MULT_LOAD;
                end
            end
            BUSY: begin
                if (count == '0) begin
                    stateNext = DONE;
                end else begin
                    countNext = count - 1'b1;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
                countNext = '0;
            end
        endcase
    end

    // FSM state and latency counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    // Sticky flag: a start request while the unit is occupied is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            protoError <= 1'b0;
        end else if (startMulDiv && (state != IDLE)) begin
            protoError <= 1'b1;
        end
    end

    // Performance counter of stalled cycles, saturating instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stallCount <= 16'd0;
        end else if (stall && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'd1;
        end
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control stage sitting between the operand forwarding logic and the PC, IF/ID and ID/EX registers.
- Detects hazards that forwarding alone cannot cover:
  - load-use in EX;
  - branch/jr in ID depending on a load;
  - accesses to the multi-cycle multiply/divide unit while it is busy.
- Drives the stall/bubble controls.
- Owns the mult/div busy FSM, the HI/LO write strobe and a stall performance counter.

Parameters:
- MULT_LAT, 4, mult/multu execution cycles (BUSY-state length); legal range 1 to 2^CNT_W.
- DIV_LAT, 32, div/divu execution cycles (BUSY-state length); legal range 1 to 2^CNT_W.
- CNT_W, 6, width of the latency down-counter.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- rsID  in  5  rs field of instruction in ID
- rtID  in  5  rt field of instruction in ID
- usesRsID  in  1  ID instruction reads rs
- usesRtID  in  1  ID instruction reads rt
- branchID  in  1  ID instruction is beq/bne/jr (compared/resolved in ID)
- hiloReadID  in  1  ID instruction is mfhi/mflo
- mulDivID  in  1  ID instruction is mult/multu/div/divu
- destRegEX  in  5  destination register of EX instruction
- regWriteEX  in  1  EX instruction writes register file
- memReadEX  in  1  EX instruction is a load
- destRegMEM  in  5  destination register of MEM instruction
- memReadMEM  in  1  MEM instruction is a load
- startMulDiv  in  1  EX holds a valid mult/div this cycle
- isDivEX  in  1  qualifies startMulDiv: 1=div, 0=mult
- stallPC  out  1  hold PC
- stallIFID  out  1  hold IF/ID register
- bubbleIDEX  out  1  load NOP into ID/EX
- mulDivBusy  out  1  mult/div unit occupied
- hiloWrite  out  1  one-cycle HI/LO write strobe
- protoError  out  1  sticky: startMulDiv while not IDLE
- stallCount  out  16  saturating count of stalled cycles

Behaviour:
- Reset, asynchronous, any time including mid-operation:
  - FSM to IDLE, counter to 0, protoError to 0, stallCount to 0.
  - All combinational outputs then evaluate to 0 given IDLE state.
- Register 0 never causes a hazard: any match against destination 0 is ignored.
- loadUse = memReadEX & regWriteEX & ((usesRsID & rsID==destRegEX) | (usesRtID & rtID==destRegEX)).
- branchLoad = branchID & ((memReadEX & regWriteEX & match on EX) | (memReadMEM & match on MEM)), where a match tests rsID/rtID against the destination register, gated by usesRsID/usesRtID.
  - Consequence: a branch behind a load stalls 2 cycles; behind a load already in MEM, 1 cycle.
  - Branch behind an ALU op in EX: no stall (forwarded to ID).
- mdHazard = mulDivBusy & (hiloReadID | mulDivID).
- stall = loadUse | branchLoad | mdHazard, all combinational, same cycle.
  - stallPC = stallIFID = bubbleIDEX = stall.
  - Causes are OR-ed; no priority needed.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: when startMulDiv, go to BUSY and load count = (isDivEX ? DIV_LAT : MULT_LAT) - 1, truncated to CNT_W.
  - BUSY: if count==0 go to DONE, else count decrements.
  - DONE: hiloWrite=1 for exactly this cycle; next state IDLE.
  - mulDivBusy = (state != IDLE), so it covers DONE as well: HI/LO is written at the end of DONE and there is no HI/LO forwarding.
  - Total: start edge, then LAT BUSY cycles, then 1 DONE cycle; a dependent mfhi leaves ID on the cycle after DONE.
  - startMulDiv in BUSY/DONE: ignored, no state change; protoError set at that edge and held until reset.
  - A new startMulDiv is accepted in the same cycle the FSM is in IDLE after DONE (back-to-back allowed).
- stallCount increments at each edge where stall=1; saturates at 16'hFFFF.

Test Plan:
- lw $2 in EX (memReadEX=1, regWriteEX=1, destRegEX=2), ID add reading rs=2 -> stall=1 for that cycle. Same stimulus with usesRsID=0, or with destRegEX=0 -> stall=0.
- lw $5 in EX, beq in ID on rt=5 -> stall=1 in cycle 0. Next cycle, load in MEM (memReadMEM=1, destRegMEM=5) -> stall=1. Third cycle -> stall=0. stallCount goes 0 to 2.
- MULT_LAT=4, startMulDiv=1, isDivEX=0 at cycle 0:
  - mulDivBusy=1 for cycles 1-5, hiloWrite=1 only in cycle 5.
  - mfhi held in ID stalls cycles 1-5, is released in cycle 6.
- DIV_LAT=32 div started, reset asserted at cycle 10 mid-operation -> outputs 0 immediately (asynchronous), state IDLE. A fresh mult after reset release completes normally.
- startMulDiv pulsed while BUSY -> count/state unaffected, protoError=1 and stays 1 until reset.
- Force stall high for 70000 cycles -> stallCount saturates at 16'hFFFF, no wrap.
